eth_rx_hdr_filter: RTL and testbench



---
 rtl/eth_rx_hdr_filter.sv | 203 ++++++++++++++++++++
 tb/tb_eth_rx_hdr_filter.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/eth_rx_hdr_filter.sv
`default_nettype none
// ============================================================================
//  Module   : eth_rx_hdr_filter
//  Purpose  : Receive-side Ethernet header filter on an 8-bit AXI-Stream path.
//             Parses the 14-byte header and forwards the payload of frames
//             addressed to this station (or to broadcast) that carry the
//             accelerator EtherType. Other frames and runts are discarded.
//             Accepted and dropped frames are both counted.
//  Ports    : net_axis_clk / net_axis_rst  - clock, synchronous active-high reset
//             local_mac                    - station address, [47:40] first on wire
//             s_axis_*                     - frame bytes from the MAC
//             m_axis_*                     - header-stripped payload bytes
//             frames_accepted/_dropped     - wrapping statistics counters
//  Revision : 1.0 - initial release
// ============================================================================
module eth_rx_hdr_filter #(
   parameter logic [15:0] ETHERTYPE    = 16'h88B5,
   parameter bit          ACCEPT_BCAST = 1'b1,
   parameter int          CNT_WIDTH    = 16
) (
   input  logic                 net_axis_clk,
   input  logic                 net_axis_rst,
   input  logic [47:0]          local_mac,
   input  logic [7:0]           s_axis_tdata,
   input  logic                 s_axis_tvalid,
   input  logic                 s_axis_tlast,
   output logic                 s_axis_tready,
   output logic [7:0]           m_axis_tdata,
   output logic                 m_axis_tvalid,
   output logic                 m_axis_tlast,
   input  logic                 m_axis_tready,
   output logic [CNT_WIDTH-1:0] frames_accepted,
   output logic [CNT_WIDTH-1:0] frames_dropped
);

   typedef enum logic [1:0] {
      ST_HDR  = 2'd0,
      ST_FWD  = 2'd1,
      ST_DROP = 2'd2
   } state_t;

   localparam logic [3:0] C_IDX_MAC_END = 4'd6;
   localparam logic [3:0] C_IDX_TYPE_HI = 4'd12;
   localparam logic [3:0] C_IDX_TYPE_LO = 4'd13;

   state_t               state_q,    state_d;
   logic [3:0]           idx_q,      idx_d;
   logic                 uc_ok_q,    uc_ok_d;
   logic                 bc_ok_q,    bc_ok_d;
   logic                 type_ok_q,  type_ok_d;
   logic [7:0]           out_data_q, out_data_d;
   logic                 out_last_q, out_last_d;
   logic                 out_vld_q,  out_vld_d;
   logic [CNT_WIDTH-1:0] acc_cnt_q,  acc_cnt_d;
   logic [CNT_WIDTH-1:0] drop_cnt_q, drop_cnt_d;

   logic       s_ready;
   logic       s_fire;
   logic       load;
   logic [7:0] mac_byte;
   logic       hdr_accept;

   // Only the forwarding state can be backpressured; the output register is
   // a single entry, so a byte may enter when it is empty or draining.
   // The reset gate keeps the port closed for the whole reset cycle.
   always_comb begin
      s_ready       = (state_q != ST_FWD) || !out_vld_q || m_axis_tready;
      s_axis_tready = s_ready && !net_axis_rst;
      s_fire        = s_axis_tvalid && s_axis_tready;
   end

   // Station address byte expected at the current header index.
   always_comb begin
      case (idx_q)
         4'd0:    mac_byte = local_mac[47:40];
         4'd1:    mac_byte = local_mac[39:32];
         4'd2:    mac_byte = local_mac[31:24];
         4'd3:    mac_byte = local_mac[23:16];
         4'd4:    mac_byte = local_mac[15:8];
         4'd5:    mac_byte = local_mac[7:0];
         default: mac_byte = 8'h00;
      endcase
   end

   // Decision on the final header byte uses the live low EtherType byte so
   // the state change lands on the same edge as that byte's transfer.
   always_comb begin
      hdr_accept = type_ok_q && (s_axis_tdata == ETHERTYPE[7:0]) &&
                   (uc_ok_q || (ACCEPT_BCAST && bc_ok_q));
   end

   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      uc_ok_d    = uc_ok_q;
      bc_ok_d    = bc_ok_q;
      type_ok_d  = type_ok_q;
      acc_cnt_d  = acc_cnt_q;
      drop_cnt_d = drop_cnt_q;
      load       = 1'b0;

      case (state_q)
         ST_HDR: begin
            if (s_fire) begin
               // Byte 0 restarts the running match so stale flags never leak
               // from a previous frame.
               if (idx_q < C_IDX_MAC_END) begin
                  uc_ok_d = ((idx_q == 4'd0) || uc_ok_q) && (s_axis_tdata == mac_byte);
                  bc_ok_d = ((idx_q == 4'd0) || bc_ok_q) && (s_axis_tdata == 8'hFF);
               end
               if (idx_q == C_IDX_TYPE_HI) begin
                  type_ok_d = (s_axis_tdata == ETHERTYPE[15:8]);
               end

               if (s_axis_tlast) begin
                  // Runt or header-only frame.
                  drop_cnt_d = drop_cnt_q + CNT_WIDTH'(1);
                  idx_d      = 4'd0;
               end else if (idx_q == C_IDX_TYPE_LO) begin
                  idx_d   = 4'd0;
                  state_d = hdr_accept ? ST_FWD : ST_DROP;
               end else begin
                  idx_d = idx_q + 4'd1;
               end
            end
         end

         ST_FWD: begin
            if (s_fire) begin
               load = 1'b1;
               if (s_axis_tlast) begin
                  acc_cnt_d = acc_cnt_q + CNT_WIDTH'(1);
                  idx_d     = 4'd0;
                  state_d   = ST_HDR;
               end
            end
         end

         ST_DROP: begin
            if (s_fire && s_axis_tlast) begin
               drop_cnt_d = drop_cnt_q + CNT_WIDTH'(1);
               idx_d      = 4'd0;
               state_d    = ST_HDR;
            end
         end

         default: begin
            state_d = ST_HDR;
            idx_d   = 4'd0;
         end
      endcase
   end

   // Output register: a new load always wins over a drain in the same cycle.
   always_comb begin
      out_data_d = out_data_q;
      out_last_d = out_last_q;
      out_vld_d  = out_vld_q;
      if (load) begin
         out_data_d = s_axis_tdata;
         out_last_d = s_axis_tlast;
         out_vld_d  = 1'b1;
      end else if (m_axis_tready) begin
         out_vld_d  = 1'b0;
      end
   end

   always_ff @(posedge net_axis_clk) begin
      if (net_axis_rst) begin
         state_q    <= ST_HDR;
         idx_q      <= 4'd0;
         uc_ok_q    <= 1'b0;
         bc_ok_q    <= 1'b0;
         type_ok_q  <= 1'b0;
         out_data_q <= 8'h00;
         out_last_q <= 1'b0;
         out_vld_q  <= 1'b0;
         acc_cnt_q  <= '0;
         drop_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         uc_ok_q    <= uc_ok_d;
         bc_ok_q    <= bc_ok_d;
         type_ok_q  <= type_ok_d;
         out_data_q <= out_data_d;
         out_last_q <= out_last_d;
         out_vld_q  <= out_vld_d;
         acc_cnt_q  <= acc_cnt_d;
         drop_cnt_q <= drop_cnt_d;
      end
   end

   always_comb begin
      m_axis_tdata    = out_data_q;
      m_axis_tlast    = out_last_q;
      m_axis_tvalid   = out_vld_q;
      frames_accepted = acc_cnt_q;
      frames_dropped  = drop_cnt_q;
   end

endmodule
`default_nettype wire

// File: tb/tb_eth_rx_hdr_filter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_eth_rx_hdr_filter
//  Purpose  : Directed self-checking bench for eth_rx_hdr_filter. Two
//             instances share the input stream: one accepts broadcast, one
//             does not.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_eth_rx_hdr_filter;

   localparam logic [47:0] C_MAC   = 48'h02_00_00_00_00_01;
   localparam logic [47:0] C_BCAST = 48'hFF_FF_FF_FF_FF_FF;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [7:0]  s_tdata = 8'h00;
   logic        s_tvalid = 1'b0;
   logic        s_tlast = 1'b0;
   logic        s_tready, s_tready0;
   logic [7:0]  m_tdata, m_tdata0;
   logic        m_tvalid, m_tvalid0;
   logic        m_tlast, m_tlast0;
   logic        m_tready = 1'b1;
   logic [15:0] acc1, drop1, acc0, drop0;

   int checks_cnt = 0;
   int errors_cnt = 0;
   int cyc = 0;
   int stall_cnt = 0;
   bit rand_en = 1'b0;
   bit seen1 = 1'b0;
   bit seen0 = 1'b0;
   bit prev_stall = 1'b0;
   logic [8:0] prev_word = '0;
   int exp_acc1 = 0, exp_drop1 = 0, exp_acc0 = 0, exp_drop0 = 0;

   logic [7:0] frm[$];
   int         in_cyc_q[$];
   logic [8:0] exp_q[$];
   logic [8:0] got_q[$];
   int         got_cyc[$];

   eth_rx_hdr_filter #(.ETHERTYPE(16'h88B5), .ACCEPT_BCAST(1'b1), .CNT_WIDTH(16)) u_dut (
      .net_axis_clk(clk), .net_axis_rst(rst), .local_mac(C_MAC),
      .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tlast(s_tlast),
      .s_axis_tready(s_tready),
      .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tlast(m_tlast),
      .m_axis_tready(m_tready),
      .frames_accepted(acc1), .frames_dropped(drop1));

   eth_rx_hdr_filter #(.ETHERTYPE(16'h88B5), .ACCEPT_BCAST(1'b0), .CNT_WIDTH(16)) u_dut_nb (
      .net_axis_clk(clk), .net_axis_rst(rst), .local_mac(C_MAC),
      .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tlast(s_tlast),
      .s_axis_tready(s_tready0),
      .m_axis_tdata(m_tdata0), .m_axis_tvalid(m_tvalid0), .m_axis_tlast(m_tlast0),
      .m_axis_tready(m_tready),
      .frames_accepted(acc0), .frames_dropped(drop0));

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) begin
      #1;
      m_tready = rand_en ? ($urandom_range(0, 1) == 1) : 1'b1;
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks_cnt++;
      if (got !== exp) begin
         errors_cnt++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Output monitor: captures accepted beats and checks hold-under-stall.
   always @(negedge clk) begin
      if (!rst) begin
         if (prev_stall) begin
            chk("stall_valid", 64'(m_tvalid), 64'd1);
            chk("stall_word", 64'({m_tlast, m_tdata}), 64'(prev_word));
         end
         if (m_tvalid)  seen1 = 1'b1;
         if (m_tvalid0) seen0 = 1'b1;
         if (m_tvalid && m_tready) begin
            got_q.push_back({m_tlast, m_tdata});
            got_cyc.push_back(cyc);
         end
         prev_stall = m_tvalid && !m_tready;
         prev_word  = {m_tlast, m_tdata};
      end else begin
         prev_stall = 1'b0;
      end
   end

   task automatic send_byte(input logic [7:0] d, input logic l);
      bit fire;
      int c;
      s_tdata  = d;
      s_tlast  = l;
      s_tvalid = 1'b1;
      for (int n = 0; n < 1000; n++) begin
         @(negedge clk);
         fire = s_tready;
         c    = cyc;
         if (!fire) stall_cnt++;
         @(posedge clk);
         #1;
         if (fire) begin
            in_cyc_q.push_back(c);
            s_tvalid = 1'b0;
            return;
         end
      end
      chk("in_timeout", 64'd0, 64'd1);
      s_tvalid = 1'b0;
   endtask

   task automatic add_hdr(input logic [47:0] dst, input logic [15:0] et);
      for (int i = 5; i >= 0; i--) frm.push_back(dst[i*8 +: 8]);
      for (int i = 5; i >= 0; i--) frm.push_back(8'(48'h02_00_00_00_00_99 >> (i*8)));
      frm.push_back(et[15:8]);
      frm.push_back(et[7:0]);
   endtask

   task automatic add_pay(input logic [7:0] b, input bit last_b, input bit expect_out);
      frm.push_back(b);
      if (expect_out) exp_q.push_back({last_b, b});
   endtask

   task automatic send_frame();
      in_cyc_q.delete();
      for (int i = 0; i < frm.size(); i++) send_byte(frm[i], i == frm.size() - 1);
      frm.delete();
   endtask

   task automatic drain();
      bit done = 1'b0;
      for (int n = 0; n < 400 && !done; n++) begin
         @(negedge clk);
         if (got_q.size() >= exp_q.size() && !m_tvalid) done = 1'b1;
      end
      if (!done) chk("drain_timeout", 64'd0, 64'd1);
      @(posedge clk);
      #1;
   endtask

   task automatic compare_out(input string tag);
      chk({tag, "_len"}, 64'(got_q.size()), 64'(exp_q.size()));
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
         chk({tag, "_beat"}, 64'(got_q[i]), 64'(exp_q[i]));
      got_q.delete();
      got_cyc.delete();
      exp_q.delete();
   endtask

   task automatic check_cnt(input string tag);
      chk({tag, "_acc"},   64'(acc1),  64'(exp_acc1));
      chk({tag, "_drop"},  64'(drop1), 64'(exp_drop1));
      chk({tag, "_acc0"},  64'(acc0),  64'(exp_acc0));
      chk({tag, "_drop0"}, 64'(drop0), 64'(exp_drop0));
   endtask

   task automatic valid_frame(input int n, input logic [7:0] base);
      add_hdr(C_MAC, 16'h88B5);
      for (int i = 0; i < n; i++) add_pay(base + 8'(i), i == n - 1, 1'b1);
      send_frame();
      exp_acc1++;
      exp_acc0++;
   endtask

   initial begin
      // Reset behaviour
      @(negedge clk);
      chk("rst_s_tready", 64'(s_tready), 64'd0);
      chk("rst_m_tvalid", 64'(m_tvalid), 64'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("post_rst_s_tready", 64'(s_tready), 64'd1);
      chk("post_rst_m_word", 64'({m_tvalid, m_tlast, m_tdata}), 64'd0);
      check_cnt("post_rst");
      @(posedge clk);
      #1;

      // Unicast match, latency and throughput
      add_hdr(C_MAC, 16'h88B5);
      add_pay(8'hA1, 1'b0, 1'b1);
      add_pay(8'hA2, 1'b0, 1'b1);
      add_pay(8'hA3, 1'b0, 1'b1);
      add_pay(8'hA4, 1'b1, 1'b1);
      send_frame();
      exp_acc1++;
      exp_acc0++;
      drain();
      if (got_cyc.size() == 4 && in_cyc_q.size() == 18) begin
         chk("latency", 64'(got_cyc[0]), 64'(in_cyc_q[14] + 1));
         chk("throughput", 64'(got_cyc[3]), 64'(got_cyc[0] + 3));
      end else begin
         chk("t1_beats_seen", 64'(got_cyc.size()), 64'd4);
      end
      compare_out("t1");
      check_cnt("t1");

      // Broadcast: accepted only by the broadcast-enabled instance
      seen0 = 1'b0;
      add_hdr(C_BCAST, 16'h88B5);
      add_pay(8'h55, 1'b0, 1'b1);
      add_pay(8'h66, 1'b1, 1'b1);
      send_frame();
      exp_acc1++;
      exp_drop0++;
      drain();
      compare_out("bcast");
      chk("bcast_nb_novalid", 64'(seen0), 64'd0);
      check_cnt("bcast");

      // Wrong EtherType, then a back-to-back valid frame
      seen1 = 1'b0;
      stall_cnt = 0;
      add_hdr(C_MAC, 16'h0800);
      for (int i = 0; i < 46; i++) add_pay(8'(i + 8'h10), i == 45, 1'b0);
      send_frame();
      exp_drop1++;
      exp_drop0++;
      chk("type_novalid", 64'(seen1), 64'd0);
      chk("type_nostall", 64'(stall_cnt), 64'd0);
      valid_frame(6, 8'hC0);
      drain();
      compare_out("b2b");
      check_cnt("type");

      // Runt (10 bytes) and header-only (14 bytes) frames
      seen1 = 1'b0;
      for (int i = 0; i < 10; i++) frm.push_back(8'(i));
      send_frame();
      add_hdr(C_MAC, 16'h88B5);
      send_frame();
      exp_drop1 += 2;
      exp_drop0 += 2;
      chk("runt_novalid", 64'(seen1), 64'd0);
      check_cnt("runt");
      valid_frame(3, 8'hD0);
      drain();
      compare_out("after_runt");
      check_cnt("after_runt");

      // 64-byte payload under random backpressure
      rand_en = 1'b1;
      valid_frame(64, 8'h00);
      drain();
      rand_en = 1'b0;
      drain();
      compare_out("bp");
      check_cnt("bp");

      // Reset after the 5th payload byte of a valid frame
      add_hdr(C_MAC, 16'h88B5);
      for (int i = 0; i < 5; i++) add_pay(8'(8'h40 + i), 1'b0, i < 4);
      for (int i = 0; i < frm.size(); i++) send_byte(frm[i], 1'b0);
      frm.delete();
      rst = 1'b1;
      @(negedge clk);
      chk("mid_rst_s_tready", 64'(s_tready), 64'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      exp_acc1 = 0;
      exp_drop1 = 0;
      exp_acc0 = 0;
      exp_drop0 = 0;
      @(negedge clk);
      chk("mid_rst_m_tvalid", 64'(m_tvalid), 64'd0);
      chk("mid_rst_s_tready1", 64'(s_tready), 64'd1);
      check_cnt("mid_rst");
      @(posedge clk);
      #1;
      for (int i = 5; i < 10; i++) frm.push_back(8'(8'h40 + i));
      send_frame();
      exp_drop1++;
      exp_drop0++;
      valid_frame(4, 8'hE0);
      drain();
      compare_out("rst_frame");
      check_cnt("rst_frame");

      $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
`default_nettype wire
